// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the fetch sequencer and its branch-target table.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    localparam int PC_W_DEF      = 10;
    localparam int LUT_IDX_W_DEF = 5;
    localparam int START_ADDR    = 0;

endpackage

// File: rtl/fetch_sequencer_branch_lut.sv
// Branch-target table: instruction field -> absolute PC, fixed at elaboration.
module branch_lut
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int LUT_IDX_W  = LUT_IDX_W_DEF,
    parameter int START_ADDR = fetch_sequencer_pkg::START_ADDR
) (
    input  logic [LUT_IDX_W-1:0] lut_idx,
    output logic [PC_W-1:0]      target
);

    always_comb begin
        target = PC_W'(START_ADDR);
        case (lut_idx)
            LUT_IDX_W'(1): target = '1;          // top of memory, exercises PC wrap
            LUT_IDX_W'(2): target = PC_W'(16);
            LUT_IDX_W'(3): target = PC_W'(40);
            LUT_IDX_W'(4): target = PC_W'(100);
            default:       target = PC_W'(START_ADDR);
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: steps/branches the PC one instruction per cycle
// from ALU branch outcomes, with run/halt status and a retired-instruction count.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int LUT_IDX_W  = LUT_IDX_W_DEF,
    parameter int START_ADDR = fetch_sequencer_pkg::START_ADDR,
    parameter int CNT_W      = 16
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 branch_taken,
    input  logic                 branch_skip,
    input  logic [LUT_IDX_W-1:0] lut_idx,
    output logic [PC_W-1:0]      pc_out,
    output logic                 running,
    output logic                 done,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 seq_err
);

    seq_state_e        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, target;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    branch_lut #(
        .PC_W       (PC_W),
        .LUT_IDX_W  (LUT_IDX_W),
        .START_ADDR (START_ADDR)
    ) u_lut (
        .lut_idx (lut_idx),
        .target  (target)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_W'(START_ADDR);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = PC_W'(START_ADDR);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                // halt_req counts as a retired instruction too
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
                if (branch_taken && branch_skip)
                    err_d = 1'b1;
                if (halt_req)
                    state_d = ST_HALT;
                else if (branch_taken)
                    pc_d = target;
                else if (branch_skip)
                    pc_d = pc_q + PC_W'(2);
                else
                    pc_d = pc_q + PC_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pc_out      = pc_q;
    assign running     = (state_q == ST_RUN);
    assign done        = (state_q == ST_HALT);
    assign instr_count = cnt_q;
    assign seq_err     = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; counter narrowed to 4 bits to reach saturation.
module tb_fetch_sequencer;

    localparam int PC_W      = 10;
    localparam int LUT_IDX_W = 5;
    localparam int CNT_W     = 4;

    logic                 CLK = 1'b0;
    logic                 Reset_n;
    logic                 start, halt_req, branch_taken, branch_skip;
    logic [LUT_IDX_W-1:0] lut_idx;
    logic [PC_W-1:0]      pc_out;
    logic                 running, done, seq_err;
    logic [CNT_W-1:0]     instr_count;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(
        .PC_W       (PC_W),
        .LUT_IDX_W  (LUT_IDX_W),
        .START_ADDR (0),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK          (CLK),
        .Reset_n      (Reset_n),
        .start        (start),
        .halt_req     (halt_req),
        .branch_taken (branch_taken),
        .branch_skip  (branch_skip),
        .lut_idx      (lut_idx),
        .pc_out       (pc_out),
        .running      (running),
        .done         (done),
        .instr_count  (instr_count),
        .seq_err      (seq_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_st(input string tag, input int pc, input int cnt,
                          input logic run, input logic dn, input logic err);
        chk({tag, ".pc"},  32'(pc_out),      32'(pc));
        chk({tag, ".cnt"}, 32'(instr_count), 32'(cnt));
        chk({tag, ".run"}, 32'(running),     32'(run));
        chk({tag, ".done"},32'(done),        32'(dn));
        chk({tag, ".err"}, 32'(seq_err),     32'(err));
    endtask

    task automatic clr_in();
        start = 0; halt_req = 0; branch_taken = 0; branch_skip = 0; lut_idx = '0;
    endtask

    initial begin
        Reset_n = 1'b0;
        clr_in();
        #23;
        chk_st("reset", 0, 0, 0, 0, 0);
        Reset_n = 1'b1;
        step(2);
        chk_st("idle_hold", 0, 0, 0, 0, 0);

        // start and sequential stepping
        start = 1; step(1); start = 0;
        chk_st("start", 0, 0, 1, 0, 0);
        step(1); chk("seq1", 32'(pc_out), 1);
        step(1); chk("seq2", 32'(pc_out), 2);
        step(1); chk("seq3", 32'(pc_out), 3);
        step(1); chk_st("seq4", 4, 4, 1, 0, 0);
        step(1); chk("seq5", 32'(pc_out), 5);

        // taken via lut[3]=40, then skip
        branch_taken = 1; lut_idx = 3; step(1); branch_taken = 0;
        chk_st("taken40", 40, 6, 1, 0, 0);
        branch_skip = 1; step(1); branch_skip = 0;
        chk_st("skip42", 42, 7, 1, 0, 0);

        // wrap: lut[1]=1023, +1 -> 0, +2 -> 1
        branch_taken = 1; lut_idx = 1; step(1); branch_taken = 0;
        chk("to1023a", 32'(pc_out), 1023);
        step(1); chk("wrap_inc", 32'(pc_out), 0);
        branch_taken = 1; step(1); branch_taken = 0;
        chk("to1023b", 32'(pc_out), 1023);
        branch_skip = 1; step(1); branch_skip = 0;
        chk_st("wrap_skip", 1, 11, 1, 0, 0);

        // counter saturation
        step(4); chk_st("cnt15", 5, 15, 1, 0, 0);
        step(1); chk_st("cnt_sat", 6, 15, 1, 0, 0);

        // start ignored while running
        start = 1; step(1); start = 0;
        chk_st("start_in_run", 7, 15, 1, 0, 0);
        halt_req = 1; step(1); halt_req = 0;
        chk_st("halt_sat", 7, 15, 0, 1, 0);

        // restart, halt at pc 7 after 7 instructions
        start = 1; step(1); start = 0;
        chk_st("restart", 0, 0, 1, 0, 0);
        step(7); chk_st("pc7", 7, 7, 1, 0, 0);
        halt_req = 1; step(1); halt_req = 0;
        chk_st("halt", 7, 8, 0, 1, 0);
        branch_taken = 1; branch_skip = 1; halt_req = 1; lut_idx = 3;
        step(2);
        clr_in();
        chk_st("halt_frozen", 7, 8, 0, 1, 0);
        start = 1; step(1); start = 0;
        chk_st("halt_restart", 0, 0, 1, 0, 0);

        // both branch inputs: taken wins, sticky error
        branch_taken = 1; branch_skip = 1; lut_idx = 2; step(1); clr_in();
        chk_st("both", 16, 1, 1, 0, 1);
        step(1); chk_st("err_sticky", 17, 2, 1, 0, 1);
        branch_taken = 1; lut_idx = 9; step(1); clr_in();
        chk("unlisted_idx", 32'(pc_out), 0);
        step(12); chk("pc12a", 32'(pc_out), 12);
        halt_req = 1; step(1); halt_req = 0;
        chk_st("halt_err", 12, 15, 0, 1, 1);
        start = 1; step(1); start = 0;
        chk_st("err_clear", 0, 0, 1, 0, 0);

        // asynchronous reset mid-run at pc 12
        step(12); chk("pc12b", 32'(pc_out), 12);
        #2 Reset_n = 1'b0;
        #1 chk_st("async_rst", 0, 0, 0, 0, 0);
        #2 Reset_n = 1'b1;
        step(2); chk_st("post_rst_idle", 0, 0, 0, 0, 0);
        start = 1; step(1); start = 0;
        chk_st("post_rst_start", 0, 0, 1, 0, 0);
        step(1); chk("post_rst_pc1", 32'(pc_out), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter sequencer sitting directly downstream of the ALU's branch outputs and upstream of instruction ROM.
- Consumes branch_taken / branch_skip each executed instruction; produces next instruction address, run/done status, and executed-instruction count.
- Taken branches resolve through a small branch-target lookup table indexed by an instruction field.

Parameters:
- PC_W, 10, program counter width; instruction memory depth 2^PC_W
- LUT_IDX_W, 5, branch-target LUT index width (2^LUT_IDX_W entries)
- START_ADDR, 0, PC value loaded on start
- CNT_W, 16, executed-instruction counter width

Ports:
- CLK  input  1  system clock, rising edge
- Reset_n  input  1  asynchronous active-low reset
- start  input  1  level/pulse; sampled in IDLE or HALT to (re)start program
- halt_req  input  1  decoder's halt indication for current instruction (shift with zero amount)
- branch_taken  input  1  from ALU: BNE operands unequal
- branch_skip  input  1  from ALU: BNE operands equal
- lut_idx  input  LUT_IDX_W  branch target index from current instruction
- pc_out  output  PC_W  current instruction address
- running  output  1  high in RUN
- done  output  1  high in HALT
- instr_count  output  CNT_W  instructions retired since last start, saturating
- seq_err  output  1  sticky: branch_taken and branch_skip seen together

Behaviour:
- Reset (async, Reset_n low): state=IDLE, pc_out=START_ADDR, running=0, done=0, instr_count=0, seq_err=0. Reset mid-RUN aborts immediately; no further PC updates until start.
- States: IDLE, RUN, HALT.
- IDLE: start=1 -> RUN next edge; pc_out=START_ADDR, instr_count=0, seq_err=0. Otherwise hold.
- RUN: one instruction per cycle; on each edge, priority order:
  - halt_req=1 -> HALT; pc_out holds; instr_count+1 (halt counts as retired).
  - branch_taken=1 -> pc_out = lut[lut_idx].
  - branch_skip=1 -> pc_out = pc_out+2 (skips the slot after BNE).
  - else pc_out = pc_out+1.
  - instr_count increments every RUN edge; saturates at 2^CNT_W-1.
- Simultaneous branch_taken and branch_skip in RUN: taken wins; seq_err set, sticky until next start or reset.
- Inputs halt_req/branch_* ignored outside RUN.
- PC arithmetic modulo 2^PC_W: +1 from all-ones -> 0; +2 from all-ones -> 1.
- HALT: done=1, running=0, pc_out and instr_count frozen. start=1 -> RUN with same reload as IDLE; done drops on that edge.
- Outputs registered; pc_out changes only on CLK edge (1-cycle latency from branch inputs to new address).
- LUT: combinational read, contents fixed at elaboration (case table), entries are PC_W-bit absolute addresses; unlisted indices return START_ADDR.

Decomposition:
- Shared package: state enum (IDLE, RUN, HALT), PC_W/LUT_IDX_W defaults, START_ADDR constant.
- One sub-module: branch_lut (lut_idx -> target), combinational, separately testable.

Test Plan:
- Reset then start pulse, no branches, 4 cycles -> pc_out 0,1,2,3,4; instr_count=4; running=1, done=0.
- At PC=5 assert branch_taken with lut_idx=3 (lut[3]=40) -> pc_out=40 next cycle; then branch_skip at 40 -> pc_out=42.
- Force PC to 1023 via LUT entry (PC_W=10), no branch -> pc_out=0; branch_skip at 1023 -> pc_out=1.
- halt_req at PC=7 after 7 instructions -> done=1, pc_out stays 7, instr_count=8; toggle branch inputs -> no change; start -> pc_out=0, instr_count=0, done=0.
- branch_taken and branch_skip both high, lut_idx=2 (lut[2]=16) -> pc_out=16, seq_err=1, stays 1 until next start.
- Reset_n low asynchronously mid-RUN at PC=12 -> pc_out=0, running=0 immediately (before next edge); idle until start.
